// File: rtl/agendador_medicao_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | agendador_medicao_pkg: state codes and default timing constants      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package agendador_medicao_pkg;

  localparam logic [3:0] ST_INICIAL        = 4'd0;
  localparam logic [3:0] ST_ESPERA         = 4'd1;
  localparam logic [3:0] ST_INICIA_MEDIDA  = 4'd2;
  localparam logic [3:0] ST_AGUARDA_MEDIDA = 4'd3;
  localparam logic [3:0] ST_REGISTRA       = 4'd4;
  localparam logic [3:0] ST_TRANSMITE      = 4'd5;
  localparam logic [3:0] ST_AGUARDA_TX     = 4'd6;
  localparam logic [3:0] ST_FALHA          = 4'd7;

  localparam int unsigned PERIODO_PADRAO        = 50_000_000;
  localparam int unsigned TIMEOUT_PADRAO        = 1_000_000;
  localparam int unsigned MAX_TENTATIVAS_PADRAO = 3;

endpackage
`default_nettype wire

// File: rtl/agendador_medicao_contador_m.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | contador_m: modulo-M counter with clear (zera), enable (conta), fim  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module contador_m #(
  parameter int unsigned M = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int unsigned W = (M > 1) ? $clog2(M) : 1;
  localparam logic [W-1:0] ULTIMO = W'(M - 1);

  logic [W-1:0] valor_q, valor_d;

  always_comb begin
    valor_d = valor_q;
    if (zera) begin
      valor_d = '0;
    end else if (conta) begin
      valor_d = (valor_q == ULTIMO) ? '0 : valor_q + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valor_q <= '0;
    end else begin
      valor_q <= valor_d;
    end
  end

  assign fim = (valor_q == ULTIMO);

endmodule
`default_nettype wire

// File: rtl/agendador_medicao.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | agendador_medicao: periodic/manual sensor read with retries, then    |
// | one transmission of the latched temperature/humidity words.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module agendador_medicao
  import agendador_medicao_pkg::*;
#(
  parameter int unsigned PERIODO_CICLOS = PERIODO_PADRAO,
  parameter int unsigned TIMEOUT_CICLOS = TIMEOUT_PADRAO,
  parameter int unsigned MAX_TENTATIVAS = MAX_TENTATIVAS_PADRAO
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        habilita,
  input  logic        medir_agora,
  input  logic        sensor_pronto,
  input  logic        sensor_erro,
  input  logic [15:0] temperatura_in,
  input  logic [15:0] umidade_in,
  input  logic        pronto_transmissao,
  output logic        sensor_inicia,
  output logic        transmite,
  output logic [15:0] temperatura,
  output logic [15:0] umidade,
  output logic        ocupado,
  output logic        erro_sensor,
  output logic [3:0]  db_estado
);

  localparam logic [3:0] MAX_T = 4'(MAX_TENTATIVAS);

  logic [3:0]  estado_q, estado_d;
  logic [3:0]  tentativas_q, tentativas_d;
  logic        pendente_q, pendente_d;
  logic        erro_q, erro_d;
  logic [15:0] temperatura_q, temperatura_d;
  logic [15:0] umidade_q, umidade_d;

  logic fim_periodo, fim_timeout, tick, pedido;
  logic [3:0] tentativas_prox;

  contador_m #(.M(PERIODO_CICLOS)) u_periodo (
    .clock (clock),
    .reset (reset),
    .zera  (~habilita),
    .conta (habilita),
    .fim   (fim_periodo)
  );

  contador_m #(.M(TIMEOUT_CICLOS)) u_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (estado_q == ST_INICIA_MEDIDA),
    .conta (estado_q == ST_AGUARDA_MEDIDA),
    .fim   (fim_timeout)
  );

  assign tick            = habilita & fim_periodo;
  assign tentativas_prox = tentativas_q + 4'd1;

  always_comb begin
    estado_d      = estado_q;
    tentativas_d  = tentativas_q;
    erro_d        = erro_q;
    temperatura_d = temperatura_q;
    umidade_d     = umidade_q;
    pedido        = pendente_q | tick | medir_agora;
    case (estado_q)
      ST_INICIAL: estado_d = ST_ESPERA;
      ST_ESPERA: begin
        if (pedido) begin
          estado_d     = ST_INICIA_MEDIDA;
          tentativas_d = 4'd0;
        end
      end
      ST_INICIA_MEDIDA: estado_d = ST_AGUARDA_MEDIDA;
      ST_AGUARDA_MEDIDA: begin
        // An error pulse wins over a simultaneous pronto; pronto wins over timeout.
        if (sensor_erro || (!sensor_pronto && fim_timeout)) begin
          tentativas_d = tentativas_prox;
          estado_d     = (tentativas_prox < MAX_T) ? ST_INICIA_MEDIDA : ST_FALHA;
        end else if (sensor_pronto) begin
          estado_d      = ST_REGISTRA;
          temperatura_d = temperatura_in;
          umidade_d     = umidade_in;
        end
      end
      ST_REGISTRA: begin
        erro_d   = 1'b0;
        estado_d = ST_TRANSMITE;
      end
      ST_TRANSMITE: estado_d = ST_AGUARDA_TX;
      ST_AGUARDA_TX: begin
        if (pronto_transmissao) estado_d = ST_ESPERA;
      end
      ST_FALHA: begin
        erro_d   = 1'b1;
        estado_d = ST_ESPERA;
      end
      default: estado_d = ST_INICIAL;
    endcase
    // Requests arriving at any time collapse into one; every start consumes it.
    pendente_d = (estado_d == ST_INICIA_MEDIDA) ? 1'b0 : pedido;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q      <= ST_INICIAL;
      tentativas_q  <= 4'd0;
      pendente_q    <= 1'b0;
      erro_q        <= 1'b0;
      temperatura_q <= 16'd0;
      umidade_q     <= 16'd0;
    end else begin
      estado_q      <= estado_d;
      tentativas_q  <= tentativas_d;
      pendente_q    <= pendente_d;
      erro_q        <= erro_d;
      temperatura_q <= temperatura_d;
      umidade_q     <= umidade_d;
    end
  end

  assign sensor_inicia = (estado_q == ST_INICIA_MEDIDA);
  assign transmite     = (estado_q == ST_TRANSMITE);
  assign ocupado       = (estado_q != ST_INICIAL) && (estado_q != ST_ESPERA);
  assign erro_sensor   = erro_q;
  assign temperatura   = temperatura_q;
  assign umidade       = umidade_q;
  assign db_estado     = estado_q;

endmodule
`default_nettype wire
